ascon_bd_master: RTL and testbench

- Synthesizable host-side initiator for the ascon_engine 16-bit toggle handshake (bd_in_data/bd_in_config out, bd_out_data/bd_out_config in).
- Takes one command block per request: a 4-bit command code, 1..8 payload words, and flag bits.
- Serializes the payload MSB-word-first, waits for the engine's toggle acknowledge on each word, and gathers the returned words into a 128-bit response.
- Sits between a PS/AXI-facing register block and ascon_engine, replacing software bit-banging.

---
 rtl/ascon_bd_master.sv | 182 ++++++++++++++++++
 tb/tb_ascon_bd_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_bd_master.sv
// ascon_bd_master: host-side initiator for the ascon_engine 16-bit toggle handshake.
//
// Accepts one command block (cmd, flags, 1..8 payload words), sends the payload
// MSB-word-first over bd_in_*, waits for the engine's ack toggle on bd_out_config[2]
// after each word, and gathers the returned words into a 128-bit response.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake; req_cmd, req_flags, req_nwords, req_data
//   rsp_valid/rsp_ready      response handshake; rsp_data, rsp_auth, rsp_timeout
//   bd_in_data, bd_in_config word and {5'b0, cmd, last, flags, tx_toggle} to the engine
//   bd_out_data, bd_out_config engine reply word and status ([2] ack toggle, [3] auth)
//
// Optional feature: define ASCON_BD_TIMEOUT_EN to abort a word wait after
// TIMEOUT_CYCLES cycles without an ack (response flagged with rsp_timeout).
module ascon_bd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_cmd,
    input  logic [4:0]   req_flags,
    input  logic [3:0]   req_nwords,
    input  logic [127:0] req_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_auth,
    output logic         rsp_timeout,
    output logic [15:0]  bd_in_data,
    output logic [15:0]  bd_in_config,
    input  logic [15:0]  bd_out_data,
    input  logic [15:0]  bd_out_config
);

    typedef enum logic [1:0] {StIdle, StSend, StWait, StResp} state_e;

    state_e         state_q;
    logic [3:0]     cmd_q;
    logic [4:0]     flags_q;
    logic [3:0]     nwords_q;
    logic [3:0]     word_cnt_q;
    logic [127:0]   shift_q;
    logic [127:0]   resp_q;
    logic           tx_toggle_q;
    logic           seen_toggle_q;
    logic           first_q;       // no word sent since reset
    logic           req_ready_q;
    logic           rsp_valid_q;
    logic           rsp_auth_q;
    logic           rsp_timeout_q;
    logic [15:0]    bd_in_data_q;
    logic [15:0]    bd_in_config_q;

    logic [3:0]     nwords_clamp;
    logic           next_toggle;
    logic           ack;
    logic           last_word;

    always_comb begin
        if (req_nwords == 4'd0) begin
            nwords_clamp = 4'd1;
        end else if (req_nwords > 4'd8) begin
            nwords_clamp = 4'd8;
        end else begin
            nwords_clamp = req_nwords;
        end
    end

    // The first word after reset goes out with toggle 0; every later word flips it.
    assign next_toggle = first_q ? 1'b0 : ~tx_toggle_q;
    assign ack         = bd_out_config[2] != seen_toggle_q;
    assign last_word   = word_cnt_q == (nwords_q - 4'd1);

`ifdef ASCON_BD_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            cmd_q          <= '0;
            flags_q        <= '0;
            nwords_q       <= 4'd1;
            word_cnt_q     <= '0;
            shift_q        <= '0;
            resp_q         <= '0;
            tx_toggle_q    <= 1'b0;
            seen_toggle_q  <= 1'b0;
            first_q        <= 1'b1;
            req_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_auth_q     <= 1'b0;
            rsp_timeout_q  <= 1'b0;
            bd_in_data_q   <= '0;
            bd_in_config_q <= '0;
`ifdef ASCON_BD_TIMEOUT_EN
            wd_cnt_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        cmd_q         <= req_cmd;
                        flags_q       <= req_flags;
                        nwords_q      <= nwords_clamp;
                        shift_q       <= req_data;
                        resp_q        <= '0;
                        word_cnt_q    <= '0;
                        rsp_auth_q    <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        req_ready_q   <= 1'b0;
                        state_q       <= StSend;
                    end
                end
                StSend: begin
                    tx_toggle_q    <= next_toggle;
                    first_q        <= 1'b0;
                    bd_in_data_q   <= shift_q[127:112];
                    bd_in_config_q <= {5'b0, cmd_q, last_word, flags_q, next_toggle};
`ifdef ASCON_BD_TIMEOUT_EN
                    wd_cnt_q       <= '0;
`endif
                    state_q        <= StWait;
                end
                StWait: begin
                    if (ack) begin
                        seen_toggle_q <= bd_out_config[2];
                        resp_q        <= {resp_q[111:0], bd_out_data};
                        shift_q       <= {shift_q[111:0], 16'h0000};
                        word_cnt_q    <= word_cnt_q + 4'd1;
                        if (last_word) begin
                            rsp_auth_q  <= bd_out_config[3];
                            rsp_valid_q <= 1'b1;
                            state_q     <= StResp;
                        end else begin
                            state_q     <= StSend;
                        end
`ifdef ASCON_BD_TIMEOUT_EN
                    end else if (wd_cnt_q == TimeoutLast) begin
                        rsp_timeout_q <= 1'b1;
                        rsp_auth_q    <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= StResp;
                    end else begin
                        wd_cnt_q      <= wd_cnt_q + 16'd1;
`endif
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifndef ASCON_BD_TIMEOUT_EN
    // Without the watchdog the timeout parameter has no effect.
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    logic unused_cfg;
    assign unused_cfg = ^{bd_out_config[15:4], bd_out_config[1:0]};

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = resp_q;
    assign rsp_auth     = rsp_auth_q;
    assign rsp_timeout  = rsp_timeout_q;
    assign bd_in_data   = bd_in_data_q;
    assign bd_in_config = bd_in_config_q;

endmodule

// File: tb/tb_ascon_bd_master.sv
// Self-checking bench for ascon_bd_master: an inline engine model acks each word,
// expected bus words/config and responses come from a word-list reference model.
module tb_ascon_bd_master;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   req_cmd = '0;
    logic [4:0]   req_flags = '0;
    logic [3:0]   req_nwords = '0;
    logic [127:0] req_data = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_data;
    logic         rsp_auth;
    logic         rsp_timeout;
    logic [15:0]  bd_in_data;
    logic [15:0]  bd_in_config;
    logic [15:0]  bd_out_data = '0;
    logic [15:0]  bd_out_config = '0;

    always #5 clk = ~clk;

    ascon_bd_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_flags    (req_flags),
        .req_nwords   (req_nwords),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_auth     (rsp_auth),
        .rsp_timeout  (rsp_timeout),
        .bd_in_data   (bd_in_data),
        .bd_in_config (bd_in_config),
        .bd_out_data  (bd_out_data),
        .bd_out_config(bd_out_config)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned words_since_reset = 0;  // model: tx_toggle of word k is k mod 2
    logic        ack_tog = 1'b0;          // engine-side ack toggle

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 128'(req_ready), 128'(1'b1));
        check({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(1'b0));
        check({tag, "_rsp_data"}, rsp_data, 128'h0);
        check({tag, "_rsp_auth"}, 128'(rsp_auth), 128'(1'b0));
        check({tag, "_rsp_timeout"}, 128'(rsp_timeout), 128'(1'b0));
        check({tag, "_bd_in_data"}, 128'(bd_in_data), 128'h0);
        check({tag, "_bd_in_config"}, 128'(bd_in_config), 128'h0);
    endtask

    task automatic wait_ready();
        int i;
        i = 0;
        while (req_ready !== 1'b1 && i < 200) begin
            @(posedge clk); #1;
            i++;
        end
        check("req_ready_wait", 128'(req_ready), 128'(1'b1));
    endtask

    task automatic engine_ack(input logic [15:0] reply, input logic auth);
        ack_tog       = ~ack_tog;
        bd_out_data   = reply;
        bd_out_config = {12'($urandom), auth, ack_tog, 2'($urandom)};
    endtask

    // One full request. abort_at >= 0 asserts reset while that word is on the bus.
    task automatic run_req(input logic [3:0] cmd, input logic [4:0] flags,
                           input logic [3:0] nw, input logic [127:0] data,
                           input int dmin, input int dmax, input int hold,
                           input int abort_at);
        int           n;
        int           d;
        logic [127:0] exp_rsp;
        logic         exp_auth;
        logic [15:0]  exp_word;
        logic [15:0]  exp_cfg;
        logic [15:0]  reply;
        logic         auth;
        n        = (nw == 4'd0) ? 1 : ((nw > 4'd8) ? 8 : int'(nw));
        exp_rsp  = '0;
        exp_auth = 1'b0;
        exp_cfg  = '0;
        wait_ready();
        req_cmd    = cmd;
        req_flags  = flags;
        req_nwords = nw;
        req_data   = data;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_data  = {$urandom, $urandom, $urandom, $urandom};
        req_cmd   = 4'($urandom);
        req_flags = 5'($urandom);
        check("req_ready_busy", 128'(req_ready), 128'(1'b0));
        for (int w = 0; w < n; w++) begin
            exp_word = data[127 - 16 * w -: 16];
            exp_cfg  = {5'b0, cmd, (w == n - 1), flags, words_since_reset[0]};
            @(posedge clk); #1;
            if (w == abort_at) begin
                rst = 1'b0;
                #1;
                check_reset_outputs("abort");
                @(posedge clk); #1;
                check_reset_outputs("abort_hold");
                rst               = 1'b1;
                words_since_reset = 0;
                ack_tog           = 1'b0;
                bd_out_config     = '0;
                return;
            end
            check("word_data", 128'(bd_in_data), 128'(exp_word));
            check("word_cfg", 128'(bd_in_config), 128'(exp_cfg));
            words_since_reset++;
            d = $urandom_range(dmax, dmin);
            repeat (d) begin
                @(posedge clk); #1;
                check("wait_cfg_stable", 128'({bd_in_data, bd_in_config}),
                      128'({exp_word, exp_cfg}));
                check("wait_no_rsp", 128'(rsp_valid), 128'(1'b0));
            end
            reply = 16'($urandom);
            auth  = 1'($urandom);
            engine_ack(reply, auth);
            exp_rsp  = {exp_rsp[111:0], reply};
            exp_auth = auth;
            @(posedge clk); #1;
        end
        check("rsp_valid", 128'(rsp_valid), 128'(1'b1));
        check("rsp_data", rsp_data, exp_rsp);
        check("rsp_auth", 128'(rsp_auth), 128'(exp_auth));
        check("rsp_timeout", 128'(rsp_timeout), 128'(1'b0));
        check("req_ready_resp", 128'(req_ready), 128'(1'b0));
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_valid", 128'(rsp_valid), 128'(1'b1));
            check("hold_data", rsp_data, exp_rsp);
            check("hold_ready", 128'(req_ready), 128'(1'b0));
            check("hold_bus", 128'(bd_in_config), 128'(exp_cfg));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_done_valid", 128'(rsp_valid), 128'(1'b0));
        check("rsp_done_ready", 128'(req_ready), 128'(1'b1));
    endtask

`ifdef ASCON_BD_TIMEOUT_EN
    // Word 1 is acked, word 2 never is: response must appear on the 16th wait cycle.
    task automatic run_timeout();
        logic [15:0] reply;
        wait_ready();
        req_cmd    = 4'h3;
        req_flags  = 5'b00001;
        req_nwords = 4'd3;
        req_data   = {$urandom, $urandom, $urandom, $urandom};
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        words_since_reset++;
        reply = 16'($urandom);
        engine_ack(reply, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        words_since_reset++;
        repeat (15) begin
            @(posedge clk); #1;
            check("to_not_yet", 128'(rsp_valid), 128'(1'b0));
        end
        @(posedge clk); #1;
        check("to_valid", 128'(rsp_valid), 128'(1'b1));
        check("to_flag", 128'(rsp_timeout), 128'(1'b1));
        check("to_auth", 128'(rsp_auth), 128'(1'b0));
        check("to_data", rsp_data, 128'(reply));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("to_done", 128'(req_ready), 128'(1'b1));
    endtask
`endif

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;
        // CONF, single word
        run_req(4'h1, 5'b01100, 4'd1, {$urandom, $urandom, $urandom, $urandom}, 3, 3, 0, -1);
        // KEY, 8 words with known payload
        run_req(4'h2, 5'b00000, 4'd8, 128'h000102030405060708090A0B0C0D0E0F, 3, 3, 0, -1);
        // nwords clamping
        run_req(4'h4, 5'b00010, 4'd0, {$urandom, $urandom, $urandom, $urandom}, 0, 2, 1, -1);
        run_req(4'h5, 5'b10000, 4'd12, {$urandom, $urandom, $urandom, $urandom}, 0, 2, 1, -1);
        // fast acks, long response backpressure
        run_req(4'h6, 5'b11111, 4'd4, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 10, -1);
        // reset during word 4 of 8, then first word after reset must carry toggle 0
        run_req(4'h7, 5'b00100, 4'd8, {$urandom, $urandom, $urandom, $urandom}, 0, 3, 0, 3);
        run_req(4'h8, 5'b00011, 4'd2, {$urandom, $urandom, $urandom, $urandom}, 1, 3, 0, -1);
        for (int i = 0; i < 20; i++) begin
            run_req(4'($urandom), 5'($urandom), 4'($urandom),
                    {$urandom, $urandom, $urandom, $urandom}, 0, 4,
                    int'($urandom_range(3, 0)), -1);
        end
`ifdef ASCON_BD_TIMEOUT_EN
        run_timeout();
        run_req(4'h9, 5'b00001, 4'd3, {$urandom, $urandom, $urandom, $urandom}, 0, 2, 0, -1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
